// File: rtl/legv8_pkg.sv
// Types and constants shared by the instruction-memory loader and its helpers.
// Also reused by the CPU-side blocks that read the instruction memory.
package legv8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } ldr_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int BYTE_CNT_W  = $clog2(INSTR_BYTES);

    // Byte offset of a word index inside the instruction memory.
    function automatic logic [9:0] word_byte_offset(input logic [7:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects a little-endian byte stream into 32-bit words.
// word_ready_o flags the byte that completes a word; word_o is valid in that cycle.
module byte_word_assembler
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(INSTR_BYTES - 1);

    // Only the three earlier bytes are stored; the fourth comes straight from the input.
    logic [23:0]           shift_q;
    logic [23:0]           shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [BYTE_CNT_W-1:0] cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = {byte_i, shift_q};
    assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: count byte, 4*N little-endian data bytes, XOR checksum byte.
// Writes one instruction word per WRITE cycle and holds the CPU until a good load.
module imem_loader
    import legv8_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    ldr_state_t            state_q;
    logic [7:0]            count_q;
    logic [7:0]            word_idx_q;
    logic [7:0]            csum_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]           wr_data_q;
    logic                  wr_en_q;
    logic                  in_ready_q;
    logic                  cpu_hold_q;
    logic                  done_q;
    logic                  error_q;

    logic                  xfer;
    logic                  start_ok;
    logic                  asm_valid;
    logic                  word_ready;
    logic [31:0]           asm_word;

    assign xfer      = in_valid && in_ready_q;
    assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign asm_valid = xfer && (state_q == DATA);

    byte_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (start_ok),
        .byte_valid_i (asm_valid),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_ready_o (word_ready)
    );

    // in_ready is registered, so every transition sets it for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            wr_addr_q  <= BASE;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= COUNT;
                        in_ready_q <= 1'b1;
                        count_q    <= '0;
                        word_idx_q <= '0;
                        csum_q     <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        cpu_hold_q <= 1'b1;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        count_q <= in_data;
                        state_q <= (in_data == 8'd0) ? CHECK : DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ in_data;
                        if (word_ready) begin
                            state_q    <= WRITE;
                            in_ready_q <= 1'b0;
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= asm_word;
                            wr_addr_q  <= BASE + ADDR_WIDTH'(word_byte_offset(word_idx_q));
                        end
                    end
                end
                WRITE: begin
                    word_idx_q <= word_idx_q + 8'd1;
                    in_ready_q <= 1'b1;
                    state_q    <= (word_idx_q + 8'd1 == count_q) ? CHECK : DATA;
                end
                CHECK: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
